head_pkg_dispatch: RTL



---
 rtl/head_pkg_dispatch_pkg.sv | 27 ++
 rtl/data_inf_c.sv | 11 +
 rtl/head_pkg_dispatch_slot.sv | 28 ++
 rtl/head_pkg_dispatch.sv | 123 ++++++++++++
 4 files changed

// File: rtl/head_pkg_dispatch_pkg.sv
// Shared types for the head_pkg_dispatch slice: header struct, channel count,
// route FSM encoding and header field extractors.
package test_package;

    typedef struct packed {
        logic [3:0] op;
    } z_ing;

    localparam int HDP_NCH = 5;

    typedef enum logic [1:0] {
        OPEN     = 2'd0,
        LOCKED   = 2'd1,
        DROPPING = 2'd2
    } route_st_e;

    // Destination channel lives in op[3:1]
    function automatic logic [2:0] z_dest(input z_ing z);
        return z.op[3:1];
    endfunction

    // op[0] set means more beats follow on the same route
    function automatic logic z_hold(input z_ing z);
        return z.op[0];
    endfunction

endpackage

// File: rtl/data_inf_c.sv
// Valid/ready stream interface with a DSIZE-wide payload.
interface data_inf_c #(
    parameter int DSIZE = 8
);
    logic             valid;
    logic             ready;
    logic [DSIZE-1:0] data;

    modport master (output valid, output data, input ready);
    modport slaver (input valid, input data, output ready);
endinterface

// File: rtl/head_pkg_dispatch_slot.sv
// head_pkg_slot: one-entry register stage. A fill always wins over a drain so a
// simultaneous drain+fill keeps valid high and loads the new beat.
module head_pkg_slot #(
    parameter int DSIZE = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             fill,
    input  logic [DSIZE-1:0] din,
    input  logic             drain_rdy,
    output logic             valid,
    output logic [DSIZE-1:0] data
);

    // Hold one beat until the downstream handshake frees it
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            data  <= din;
        end else if (valid && drain_rdy) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/head_pkg_dispatch.sv
// head_pkg_dispatch: routes a header-tagged input stream to NCH output slots.
// Optional per-channel beat statistics under HEAD_PKG_DISPATCH_STAT_EN.
module head_pkg_dispatch
    import test_package::*;
#(
    parameter int DSIZE = 8,
    parameter int NCH   = HDP_NCH
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  z_ing                     struct_z,
    data_inf_c.slaver                in_inf,
    data_inf_c.master                out_inf [NCH-1:0],
`ifdef HEAD_PKG_DISPATCH_STAT_EN
    output logic [NCH-1:0][15:0]     beat_cnt,
`endif
    output logic [15:0]              drop_cnt,
    output logic                     route_err
);

    route_st_e              route_st;
    logic [2:0]             lock_dest;
    logic [2:0]             dest;
    logic                   hold;
    logic [2:0]             tgt;
    logic                   drop;
    logic                   tgt_free;
    logic                   in_ready;
    logic                   accept;
    logic [NCH-1:0]         ch_rdy;
    logic [NCH-1:0]         slot_vld;
    logic [NCH-1:0]         fill;
    logic [NCH-1:0][DSIZE-1:0] slot_data;

    assign dest = z_dest(struct_z);
    assign hold = z_hold(struct_z);

    // Resolve target and ready; never looks at in_inf.valid
    always_comb begin
        drop     = 1'b0;
        tgt      = dest;
        tgt_free = 1'b0;
        case (route_st)
            OPEN:     drop = (dest >= 3'(NCH));
            LOCKED:   tgt  = lock_dest;
            DROPPING: drop = 1'b1;
            default:  drop = 1'b1;
        endcase
        for (int i = 0; i < NCH; i++) begin
            if (tgt == 3'(i))
                tgt_free = !slot_vld[i] || ch_rdy[i];
        end
        in_ready = drop || tgt_free;
    end

    assign in_inf.ready = in_ready;
    assign accept       = in_inf.valid && in_ready;

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_ch
            assign ch_rdy[g]         = out_inf[g].ready;
            assign fill[g]           = accept && !drop && (tgt == 3'(g));
            assign out_inf[g].valid  = slot_vld[g];
            assign out_inf[g].data   = slot_data[g];

            head_pkg_slot #(.DSIZE(DSIZE)) u_slot (
                .clock     (clock),
                .rst_n     (rst_n),
                .fill      (fill[g]),
                .din       (in_inf.data),
                .drain_rdy (ch_rdy[g]),
                .valid     (slot_vld[g]),
                .data      (slot_data[g])
            );

`ifdef HEAD_PKG_DISPATCH_STAT_EN
            // Count output handshakes; wraps naturally at 16 bits
            always_ff @(posedge clock or negedge rst_n) begin
                if (!rst_n)
                    beat_cnt[g] <= '0;
                else if (slot_vld[g] && ch_rdy[g])
                    beat_cnt[g] <= beat_cnt[g] + 16'd1;
            end
`endif
        end
    endgenerate

    // Route FSM: latch the burst destination or drop mode on hold beats
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            route_st  <= OPEN;
            lock_dest <= '0;
        end else if (accept) begin
            case (route_st)
                OPEN: begin
                    if (hold && !drop) begin
                        route_st  <= LOCKED;
                        lock_dest <= dest;
                    end else if (hold) begin
                        route_st  <= DROPPING;
                    end
                end
                LOCKED:   if (!hold) route_st <= OPEN;
                DROPPING: if (!hold) route_st <= OPEN;
                default:  route_st <= OPEN;
            endcase
        end
    end

    // Drop pulse and saturating drop counter
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            route_err <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            route_err <= accept && drop;
            if (accept && drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule
